// File: rtl/rr_decoder_sched_if.sv
// Requester/decoder-side bundle of the round-robin decoder scheduler.
// master: the requester side (drives req/release_i, observes the grant).
// slave:  the scheduler itself.
interface rr_decoder_sched_if;
  logic [3:0] req;
  logic       release_i;
  logic       dec_en;
  logic [1:0] dec_sel;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout_o;

  modport master (
    output req,
    output release_i,
    input  dec_en,
    input  dec_sel,
    input  gnt,
    input  busy,
    input  timeout_o
  );

  modport slave (
    input  req,
    input  release_i,
    output dec_en,
    output dec_sel,
    output gnt,
    output busy,
    output timeout_o
  );
endinterface

// File: rtl/rr_decoder_sched.sv
// Round-robin scheduler sharing one 2x4 decoder among four requesters.
// One owner at a time, bounded hold of MAX_HOLD cycles, and a mandatory
// dead (IDLE) cycle between consecutive owners. All outputs come from
// registers only, so nothing on req reaches the decoder combinationally.
module rr_decoder_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rr_decoder_sched_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tout, tout_nxt;
  logic             found;
  logic [1:0]       winner;

  // Saturating hold-counter increment; never wraps back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  // First asserted request in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Round-robin search result for the current pointer.
  always_comb begin
    {found, winner} = rr_pick(bus.req, ptr);
  end

  // Next-state and next-register values; exits a/b take precedence over the hold limit.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    tout_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          cnt_nxt   = CNT_ONE;
        end
      end
      GRANT: begin
        if (bus.release_i || !bus.req[sel]) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LIM) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
          cnt_nxt   = '0;
          tout_nxt  = 1'b1;
        end else begin
          cnt_nxt   = sat_inc(cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and control registers; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      cnt   <= '0;
      tout  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      tout  <= tout_nxt;
    end
  end

  // Outputs decoded purely from registers.
  assign bus.dec_en    = (state == GRANT);
  assign bus.busy      = (state == GRANT);
  assign bus.dec_sel   = sel;
  assign bus.gnt       = (state == GRANT) ? (4'b0001 << sel) : 4'b0000;
  assign bus.timeout_o = tout;

endmodule
